branch_predictor_bimodal: RTL and testbench
===========================================

// Module: branch_predictor_bimodal
// PURPOSE
//  Parametrised successor predictor for the pipelined CPU: direct-mapped BTB with valid bits and full-width
//  targets, plus a per-entry 2-bit saturating-counter BHT with real training. Mode is selectable at
//  elaboration. Lookup is combinational at IF, BTB fill happens at ID, and BHT training at ID or EX.
// PARAMETERS
//  IDX_W    8                      index bits; 2**IDX_W entries; tag = WORD_SIZE-IDX_W upper PC bits
//  MODE     `BP_MODE_BIMODAL       `BP_MODE_NOT_TAKEN(0), `BP_MODE_TAKEN(1), `BP_MODE_BIMODAL(2)
//  CNT_INIT `BP_WEAK_TAKEN         counter value loaded at reset and on allocation
//  PERF_W   16                     width of performance counters (BP_PERF_CNT_EN only)
// PORTS
//  clk                          in   1       clock, posedge
//  reset                        in   1       asynchronous, active-high
//  pc                           in   WORD    PC fetched this cycle (IF)
//  update_tag                   in   1       ID: write BTB entry for pc_for_btb_update
//  pc_for_btb_update            in   WORD    ID: branch/jump PC
//  branch_target_for_btb_update in   WORD    ID: resolved target, stored full width
//  update_bht                   in   1       ID/EX: train counter for pc_for_bht_update
//  pc_for_bht_update            in   WORD    ID/EX: resolved branch PC
//  branch_taken                 in   1       actual outcome of that branch
//  branch_mispredicted          in   1       qualifies update_bht; used only by perf counters
//  tag_match                    out  1       valid entry with matching tag for pc
//  predict_taken                out  1       tag_match && direction says taken
//  branch_predicted_pc          out  WORD    predict_taken ? btb target : pc+1
//  perf_lookups / perf_mispred  out  PERF_W  BP_PERF_CNT_EN only
// BEHAVIOUR
//  - Reset (async, during or between operations): all valid=0, all counters=CNT_INIT, tags/targets=0,
//    perf counters=0. Outputs follow directly: tag_match=0, predict_taken=0, predicted pc=pc+1.
//  - Lookup is combinational, zero latency. Writes become visible on the next cycle; there is no bypass.
//  - Direction: NOT_TAKEN -> taken=0; TAKEN -> taken=1; BIMODAL -> taken=cnt[1]
//    (00 SNT, 01 WNT, 10 WT, 11 ST).
//  - BTB write (update_tag): tag/target written and valid set. If the entry was invalid or held a
//    different tag (allocation), its counter is reset to CNT_INIT. A rewrite with the same tag keeps
//    the counter.
//  - BHT train (update_bht, BIMODAL only): applied only if the entry is valid and its tag matches
//    pc_for_bht_update; otherwise ignored. Taken -> +1 saturating at 11; not taken -> -1 saturating
//    at 00.
//  - Same index, same cycle, update_tag and update_bht: the tag/target write applies, and the counter
//    takes the trained value of the old counter if the tags match; otherwise it takes CNT_INIT.
//  - Different indices in the same cycle: both updates apply independently.
//  - pc+1 wraps modulo 2**WORD_SIZE. Index = pc[IDX_W-1:0].
// CONFIGURATION
//  `BP_PERF_CNT_EN defined: perf_lookups increments every cycle that reset is low, and perf_mispred
//    increments when update_bht && branch_mispredicted. Both wrap at 2**PERF_W.
//  Undefined: ports absent, no counter logic.
// STRUCTURE
//  constants.v: `BP_MODE_*, `BP_SNT/`BP_WNT/`BP_WEAK_TAKEN/`BP_ST encodings.
//  Sub-module bp_sat_counter: 2-bit saturating next-state function (cnt, taken -> cnt_next).
// TESTING
//  1. Reset, pc=16'h0010 -> tag_match=0, predicted pc=16'h0011. Checks the zero-tag false hit is gone.
//  2. BIMODAL: update_tag pc=16'h0105, target=16'h0200, then pc=16'h0105 -> tag_match=1,
//     predicted pc=16'h0200.
//  3. Train not-taken twice at 16'h0105 -> counter 00, predicted pc=16'h0106. Train taken twice
//     -> 10, target returned. Four more taken -> holds at 11.
//  4. Alias: update_tag pc=16'h0305 (same index 05), then lookup 16'h0105 -> miss.
//     update_bht for 16'h0105 is ignored.
//  5. Same cycle update_tag and update_bht, both 16'h0305, taken, entry counter 10 -> next cycle
//     counter 11. Assert reset mid-burst -> all outputs at reset values immediately.
//  6. MODE=NOT_TAKEN with a BTB hit -> predicted pc=pc+1. With BP_PERF_CNT_EN, 10 cycles
//     and 3 mispredicts -> perf_lookups=10, perf_mispred=3.

Source files
------------

// File: rtl/branch_predictor_bimodal_pkg.sv
// Shared types and encodings for the bimodal branch predictor.
// Optional feature macro: BP_PERF_CNT_EN (performance counters).
package branch_predictor_bimodal_pkg;

  localparam int WORD_SIZE = 16;

  typedef logic [WORD_SIZE-1:0] word_t;

  typedef enum logic [1:0] {
    BP_MODE_NOT_TAKEN = 2'd0,
    BP_MODE_TAKEN     = 2'd1,
    BP_MODE_BIMODAL   = 2'd2
  } bp_mode_e;

  localparam logic [1:0] BP_SNT        = 2'b00;
  localparam logic [1:0] BP_WNT        = 2'b01;
  localparam logic [1:0] BP_WEAK_TAKEN = 2'b10;
  localparam logic [1:0] BP_ST         = 2'b11;

endpackage

// File: rtl/branch_predictor_bimodal_if.sv
// Lookup and update bundle between the pipeline and the predictor.
// Optional feature macro: BP_PERF_CNT_EN adds the perf counter outputs.
interface branch_predictor_bimodal_if #(
  parameter int PERF_W = 16
);
  import branch_predictor_bimodal_pkg::*;

  word_t pc;
  logic  update_tag;
  word_t pc_for_btb_update;
  word_t branch_target_for_btb_update;
  logic  update_bht;
  word_t pc_for_bht_update;
  logic  branch_taken;
  logic  branch_mispredicted;
  logic  tag_match;
  logic  predict_taken;
  word_t branch_predicted_pc;
`ifdef BP_PERF_CNT_EN
  logic [PERF_W-1:0] perf_lookups;
  logic [PERF_W-1:0] perf_mispred;

  modport master (
    output pc, update_tag, pc_for_btb_update,
    output branch_target_for_btb_update,
    output update_bht, pc_for_bht_update,
    output branch_taken, branch_mispredicted,
    input  tag_match, predict_taken,
    input  branch_predicted_pc,
    input  perf_lookups, perf_mispred
  );

  modport slave (
    input  pc, update_tag, pc_for_btb_update,
    input  branch_target_for_btb_update,
    input  update_bht, pc_for_bht_update,
    input  branch_taken, branch_mispredicted,
    output tag_match, predict_taken,
    output branch_predicted_pc,
    output perf_lookups, perf_mispred
  );
`else
  modport master (
    output pc, update_tag, pc_for_btb_update,
    output branch_target_for_btb_update,
    output update_bht, pc_for_bht_update,
    output branch_taken, branch_mispredicted,
    input  tag_match, predict_taken,
    input  branch_predicted_pc
  );

  modport slave (
    input  pc, update_tag, pc_for_btb_update,
    input  branch_target_for_btb_update,
    input  update_bht, pc_for_bht_update,
    input  branch_taken, branch_mispredicted,
    output tag_match, predict_taken,
    output branch_predicted_pc
  );
`endif
endinterface

// File: rtl/branch_predictor_bimodal_sat_counter.sv
// 2-bit saturating counter next-state function.
// Saturates at strongly-taken and strongly-not-taken.
module bp_sat_counter
  import branch_predictor_bimodal_pkg::*;
(
  input  logic [1:0] i_cnt,
  input  logic       i_taken,
  output logic [1:0] o_cnt_next
);

  // step toward the observed outcome, holding at the ends
  always_comb begin
    o_cnt_next = i_cnt;
    if (i_taken) begin
      if (i_cnt != BP_ST) o_cnt_next = i_cnt + 2'd1;
    end else begin
      if (i_cnt != BP_SNT) o_cnt_next = i_cnt - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor_bimodal.sv
// Direct-mapped BTB plus per-entry 2-bit BHT successor predictor.
// Optional feature macro: BP_PERF_CNT_EN (lookup/mispredict counters).
module branch_predictor_bimodal
  import branch_predictor_bimodal_pkg::*;
#(
  parameter int          IDX_W    = 8,
  parameter bp_mode_e    MODE     = BP_MODE_BIMODAL,
  parameter logic [1:0]  CNT_INIT = BP_WEAK_TAKEN,
  parameter int          PERF_W   = 16
) (
  input logic clk,
  input logic reset,
  branch_predictor_bimodal_if.slave bp
);

  localparam int TAG_W = WORD_SIZE - IDX_W;
  localparam int N     = 1 << IDX_W;

  logic [N-1:0]     r_valid;
  logic [TAG_W-1:0] r_tag    [N];
  word_t            r_target [N];
  logic [1:0]       r_cnt    [N];

  logic [IDX_W-1:0] w_idx;
  logic [TAG_W-1:0] w_tag;
  logic             w_hit;
  logic             w_dir;
  logic [IDX_W-1:0] w_widx;
  logic [TAG_W-1:0] w_wtag;
  logic [IDX_W-1:0] w_bidx;
  logic [TAG_W-1:0] w_btag;
  logic             w_bht_hit;
  logic             w_alloc;
  logic [1:0]       w_trained;
  logic [1:0]       w_wcnt;

  assign w_idx  = bp.pc[IDX_W-1:0];
  assign w_tag  = bp.pc[WORD_SIZE-1:IDX_W];
  assign w_widx = bp.pc_for_btb_update[IDX_W-1:0];
  assign w_wtag = bp.pc_for_btb_update[WORD_SIZE-1:IDX_W];
  assign w_bidx = bp.pc_for_bht_update[IDX_W-1:0];
  assign w_btag = bp.pc_for_bht_update[WORD_SIZE-1:IDX_W];

  assign w_hit = r_valid[w_idx] && (r_tag[w_idx] == w_tag);

  // direction for the fetched pc, chosen by elaboration mode
  always_comb begin
    w_dir = r_cnt[w_idx][1];
    case (MODE)
      BP_MODE_NOT_TAKEN: w_dir = 1'b0;
      BP_MODE_TAKEN:     w_dir = 1'b1;
      default:           w_dir = r_cnt[w_idx][1];
    endcase
  end

  assign bp.tag_match     = w_hit;
  assign bp.predict_taken = w_hit && w_dir;
  assign bp.branch_predicted_pc =
    bp.predict_taken ? r_target[w_idx] : bp.pc + word_t'(1);

  assign w_bht_hit = bp.update_bht
                  && (MODE == BP_MODE_BIMODAL)
                  && r_valid[w_bidx]
                  && (r_tag[w_bidx] == w_btag);

  assign w_alloc = !r_valid[w_widx] || (r_tag[w_widx] != w_wtag);

  bp_sat_counter u_sat (
    .i_cnt      (r_cnt[w_bidx]),
    .i_taken    (bp.branch_taken),
    .o_cnt_next (w_trained)
  );

  // counter value for a BTB write; allocation discards old history
  always_comb begin
    w_wcnt = r_cnt[w_widx];
    if (w_alloc)
      w_wcnt = CNT_INIT;
    else if (w_bht_hit && (w_bidx == w_widx))
      w_wcnt = w_trained;
  end

  // table state: BTB fill at ID, counter training at ID/EX
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= '0;
      for (int i = 0; i < N; i++) begin
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_cnt[i]    <= CNT_INIT;
      end
    end else begin
      if (w_bht_hit)
        r_cnt[w_bidx] <= w_trained;
      if (bp.update_tag) begin
        r_valid[w_widx]  <= 1'b1;
        r_tag[w_widx]    <= w_wtag;
        r_target[w_widx] <= bp.branch_target_for_btb_update;
        r_cnt[w_widx]    <= w_wcnt;
      end
    end
  end

`ifdef BP_PERF_CNT_EN
  logic [PERF_W-1:0] r_perf_lookups;
  logic [PERF_W-1:0] r_perf_mispred;

  // free-running lookup count and resolved-mispredict count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_perf_lookups <= '0;
      r_perf_mispred <= '0;
    end else begin
      r_perf_lookups <= r_perf_lookups + 1'b1;
      if (bp.update_bht && bp.branch_mispredicted)
        r_perf_mispred <= r_perf_mispred + 1'b1;
    end
  end

  assign bp.perf_lookups = r_perf_lookups;
  assign bp.perf_mispred = r_perf_mispred;
`else
  logic w_unused_mispred;
  assign w_unused_mispred = bp.branch_mispredicted;
`endif

endmodule

// File: tb/tb_branch_predictor_bimodal.sv
// Self-checking bench for branch_predictor_bimodal.
// Perf checks compile in when BP_PERF_CNT_EN is defined.
module tb_branch_predictor_bimodal;
  import branch_predictor_bimodal_pkg::*;

  typedef struct {
    string name;
    word_t pc;
    logic  ut;
    word_t pb;
    word_t tg;
    logic  ub;
    word_t ph;
    logic  tk;
    logic  eh;
    logic  ep;
    word_t en;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_nt = 1'b1;
  int checks = 0;
  int failures = 0;
  vec_t vecs [27];
  vec_t exp_q [$];

  always #5 clk = ~clk;

  branch_predictor_bimodal_if bpi ();
  branch_predictor_bimodal_if bpn ();

  branch_predictor_bimodal dut (
    .clk   (clk),
    .reset (rst),
    .bp    (bpi)
  );

  branch_predictor_bimodal #(
    .MODE (BP_MODE_NOT_TAKEN)
  ) dut_nt (
    .clk   (clk),
    .reset (rst_nt),
    .bp    (bpn)
  );

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", n, act, exp);
    end
  endtask

  function automatic vec_t mk(string n, word_t pc, logic ut,
                              word_t pb, word_t tg, logic ub,
                              word_t ph, logic tk, logic eh,
                              logic ep, word_t en);
    vec_t v;
    v.name = n; v.pc = pc; v.ut = ut; v.pb = pb; v.tg = tg;
    v.ub = ub; v.ph = ph; v.tk = tk; v.eh = eh; v.ep = ep;
    v.en = en;
    return v;
  endfunction

  task automatic idle_all();
    bpi.pc = '0; bpi.update_tag = 0; bpi.pc_for_btb_update = '0;
    bpi.branch_target_for_btb_update = '0; bpi.update_bht = 0;
    bpi.pc_for_bht_update = '0; bpi.branch_taken = 0;
    bpi.branch_mispredicted = 0;
    bpn.pc = '0; bpn.update_tag = 0; bpn.pc_for_btb_update = '0;
    bpn.branch_target_for_btb_update = '0; bpn.update_bht = 0;
    bpn.pc_for_bht_update = '0; bpn.branch_taken = 0;
    bpn.branch_mispredicted = 0;
  endtask

  task automatic run_vec(vec_t v);
    vec_t e;
    @(posedge clk);
    #1;
    bpi.pc = v.pc;
    bpi.update_tag = v.ut;
    bpi.pc_for_btb_update = v.pb;
    bpi.branch_target_for_btb_update = v.tg;
    bpi.update_bht = v.ub;
    bpi.pc_for_bht_update = v.ph;
    bpi.branch_taken = v.tk;
    exp_q.push_back(v);
    @(negedge clk);
    e = exp_q.pop_front();
    chk({e.name, ".hit"}, 32'(bpi.tag_match), 32'(e.eh));
    chk({e.name, ".tkn"}, 32'(bpi.predict_taken), 32'(e.ep));
    chk({e.name, ".npc"}, 32'(bpi.branch_predicted_pc), 32'(e.en));
  endtask

  initial begin
    vecs[0]  = mk("rst_lookup", 16'h0010, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0011);
    vecs[1]  = mk("fill", 16'h0105, 1, 16'h0105, 16'h0200, 0, 0, 0, 0, 0, 16'h0106);
    vecs[2]  = mk("hit", 16'h0105, 0, 0, 0, 0, 0, 0, 1, 1, 16'h0200);
    vecs[3]  = mk("nt1", 16'h0105, 0, 0, 0, 1, 16'h0105, 0, 1, 1, 16'h0200);
    vecs[4]  = mk("nt2", 16'h0105, 0, 0, 0, 1, 16'h0105, 0, 1, 0, 16'h0106);
    vecs[5]  = mk("t1", 16'h0105, 0, 0, 0, 1, 16'h0105, 1, 1, 0, 16'h0106);
    vecs[6]  = mk("t2", 16'h0105, 0, 0, 0, 1, 16'h0105, 1, 1, 0, 16'h0106);
    vecs[7]  = mk("wt", 16'h0105, 0, 0, 0, 0, 0, 0, 1, 1, 16'h0200);
    vecs[8]  = mk("sat1", 16'h0105, 0, 0, 0, 1, 16'h0105, 1, 1, 1, 16'h0200);
    vecs[9]  = mk("sat2", 16'h0105, 0, 0, 0, 1, 16'h0105, 1, 1, 1, 16'h0200);
    vecs[10] = mk("sat3", 16'h0105, 0, 0, 0, 1, 16'h0105, 1, 1, 1, 16'h0200);
    vecs[11] = mk("sat4", 16'h0105, 0, 0, 0, 1, 16'h0105, 1, 1, 1, 16'h0200);
    vecs[12] = mk("st_dec", 16'h0105, 0, 0, 0, 1, 16'h0105, 0, 1, 1, 16'h0200);
    vecs[13] = mk("wt2", 16'h0105, 0, 0, 0, 0, 0, 0, 1, 1, 16'h0200);
    vecs[14] = mk("alias_fill", 16'h0105, 1, 16'h0305, 16'h0400, 0, 0, 0, 1, 1, 16'h0200);
    vecs[15] = mk("alias_miss", 16'h0105, 0, 0, 0, 1, 16'h0105, 0, 0, 0, 16'h0106);
    vecs[16] = mk("alias_hit", 16'h0305, 0, 0, 0, 0, 0, 0, 1, 1, 16'h0400);
    vecs[17] = mk("same_cyc", 16'h0305, 1, 16'h0305, 16'h0400, 1, 16'h0305, 1, 1, 1, 16'h0400);
    vecs[18] = mk("same_dec", 16'h0305, 0, 0, 0, 1, 16'h0305, 0, 1, 1, 16'h0400);
    vecs[19] = mk("same_chk", 16'h0305, 0, 0, 0, 0, 0, 0, 1, 1, 16'h0400);
    vecs[20] = mk("alloc_bht", 16'h0305, 1, 16'h0505, 16'h0600, 1, 16'h0305, 0, 1, 1, 16'h0400);
    vecs[21] = mk("alloc_chk", 16'h0505, 0, 0, 0, 0, 0, 0, 1, 1, 16'h0600);
    vecs[22] = mk("diff_idx", 16'h0505, 1, 16'h0107, 16'h0700, 1, 16'h0505, 0, 1, 1, 16'h0600);
    vecs[23] = mk("diff_bht", 16'h0505, 0, 0, 0, 0, 0, 0, 1, 0, 16'h0506);
    vecs[24] = mk("diff_btb", 16'h0107, 0, 0, 0, 0, 0, 0, 1, 1, 16'h0700);
    vecs[25] = mk("wrap", 16'hFFFF, 1, 16'hFFFF, 16'h1234, 0, 0, 0, 0, 0, 16'h0000);
    vecs[26] = mk("wrap_hit", 16'hFFFF, 0, 0, 0, 0, 0, 0, 1, 1, 16'h1234);

    idle_all();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);

    // asynchronous reset in the middle of an update burst
    @(posedge clk);
    #1;
    bpi.pc = 16'h0107;
    bpi.update_tag = 1;
    bpi.pc_for_btb_update = 16'h0909;
    bpi.branch_target_for_btb_update = 16'h0999;
    #2 rst = 1'b1;
    #1;
    chk("midrst.hit", 32'(bpi.tag_match), 32'd0);
    chk("midrst.tkn", 32'(bpi.predict_taken), 32'd0);
    chk("midrst.npc", 32'(bpi.branch_predicted_pc), 32'h0108);
    bpi.update_tag = 0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    bpi.pc = 16'h0909;
    #1;
    chk("postrst.nofill", 32'(bpi.tag_match), 32'd0);
    bpi.pc = 16'hFFFF;
    #1;
    chk("postrst.wrap_hit", 32'(bpi.tag_match), 32'd0);
    chk("postrst.wrap_npc", 32'(bpi.branch_predicted_pc), 32'h0000);

    // not-taken mode: a BTB hit still falls through to pc+1
    @(posedge clk);
    #1 rst_nt = 1'b0;
    bpn.update_tag = 1;
    bpn.pc_for_btb_update = 16'h0105;
    bpn.branch_target_for_btb_update = 16'h0200;
    @(posedge clk);
    #1;
    bpn.update_tag = 0;
    bpn.pc = 16'h0105;
    @(negedge clk);
    chk("nt.hit", 32'(bpn.tag_match), 32'd1);
    chk("nt.tkn", 32'(bpn.predict_taken), 32'd0);
    chk("nt.npc", 32'(bpn.branch_predicted_pc), 32'h0106);

`ifdef BP_PERF_CNT_EN
    @(posedge clk);
    #1 rst_nt = 1'b1;
    chk("perf.rst_look", 32'(bpn.perf_lookups), 32'd0);
    chk("perf.rst_misp", 32'(bpn.perf_mispred), 32'd0);
    @(negedge clk);
    rst_nt = 1'b0;
    for (int c = 0; c < 10; c++) begin
      bpn.update_bht = (c == 1) || (c == 4) || (c == 7);
      bpn.branch_mispredicted = 1'b1;
      @(posedge clk);
      #1;
    end
    bpn.update_bht = 0;
    bpn.branch_mispredicted = 0;
    chk("perf.lookups", 32'(bpn.perf_lookups), 32'd10);
    chk("perf.mispred", 32'(bpn.perf_mispred), 32'd3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
